// File: rtl/bit6_seq_divider.sv
// bit6_seq_divider: 6-bit unsigned restoring divider, one quotient bit per cycle.
// A start/done handshake with a busy flag wraps the iteration. A zero divisor
// goes straight to DONE and returns an all-ones quotient with the dividend as
// the remainder.
module bit6_seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:1] a,
  input  logic [6:1] b,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [6:1] quotient,
  output logic [6:1] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:1] pr_q,    pr_d;     // partial remainder
  logic [6:1] dq_q,    dq_d;     // dividend shifting out, quotient bits shifting in
  logic [6:1] dv_q,    dv_d;     // captured divisor
  logic [3:1] cnt_q,   cnt_d;    // step counter, 0..5
  logic [6:1] quo_q,   quo_d;
  logic [6:1] rem_q,   rem_d;
  logic       dbz_q,   dbz_d;

  logic [8:1] step;              // {quotient bit, next partial remainder}

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor, and keep the difference only when no borrow occurs.
  function automatic logic [8:1] restore_step(input logic [7:1] pr,
                                              input logic       msb,
                                              input logic [6:1] dv);
    logic [7:1] t;
    logic [8:1] d;
    t = {pr[6:1], msb};
    d = {1'b0, t} - {2'b00, dv};
    if (d[8]) begin
      restore_step = {1'b0, t};
    end else begin
      restore_step = {1'b1, d[7:1]};
    end
  endfunction

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    pr_d    = pr_q;
    dq_d    = dq_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    step    = restore_step(pr_q, dq_q[6], dv_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dq_d  = a;
          dv_d  = b;
          pr_d  = 7'd0;
          cnt_d = 3'd0;
          if (b == 6'd0) begin
            // Nothing to iterate: report the divide-by-zero result at once.
            state_d = S_DONE;
            quo_d   = 6'b111111;
            rem_d   = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        pr_d  = step[7:1];
        dq_d  = {dq_q[5:1], step[8]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          // Sixth step: publish the result on the same edge that enters DONE.
          state_d = S_DONE;
          quo_d   = {dq_q[5:1], step[8]};
          rem_d   = step[6:1];
          dbz_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pr_q    <= 7'd0;
      dq_q    <= 6'd0;
      dv_q    <= 6'd0;
      cnt_q   <= 3'd0;
      quo_q   <= 6'd0;
      rem_q   <= 6'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pr_q    <= pr_d;
      dq_q    <= dq_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags decode straight from the state register.
  assign ready       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_bit6_seq_divider.sv
// Directed and exhaustive bench for bit6_seq_divider.
module tb_bit6_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:1] a;
  logic [6:1] b;
  logic       ready;
  logic       busy;
  logic       done;
  logic [6:1] quotient;
  logic [6:1] remainder;
  logic       div_by_zero;

  int n_vec;
  int n_err;
  int exp_dones;
  int seen_dones;

  bit6_seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which a result is presented.
  always @(negedge clk) begin
    if (done === 1'b1) seen_dones = seen_dones + 1;
  end

  // Hard stop so the run cannot hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count RUN cycles until busy drops, bounded.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n = n + 1;
    end
  endtask

  // One complete division from a 1-cycle start pulse.
  task automatic run_div(input string tag, input logic [6:1] ai, input logic [6:1] bi,
                         input logic [6:1] eq, input logic [6:1] er, input logic ez,
                         input bit full);
    int n;
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_dones = exp_dones + 1;
    if (bi == 6'd0) begin
      chk({tag, "_dz_done_next_cycle"}, done, 1);
      if (full) chk({tag, "_dz_busy"}, busy, 0);
    end else begin
      if (full) chk({tag, "_busy_after_accept"}, busy, 1);
      wait_busy(n);
      if (full) chk({tag, "_busy_cycles"}, n, 6);
      chk({tag, "_done"}, done, 1);
    end
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    @(posedge clk); #1;
    if (full) begin
      chk({tag, "_done_one_cycle"}, done, 0);
      chk({tag, "_ready_after"}, ready, 1);
      chk({tag, "_quotient_held"}, quotient, eq);
    end
  endtask

  initial begin
    int n;
    n_vec = 0; n_err = 0; exp_dones = 0; seen_dones = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    run_div("d45_7",  6'd45, 6'd7,  6'd6,  6'd3,  1'b0, 1'b1);
    run_div("d63_1",  6'd63, 6'd1,  6'd63, 6'd0,  1'b0, 1'b1);
    run_div("d5_9",   6'd5,  6'd9,  6'd0,  6'd5,  1'b0, 1'b1);
    run_div("d63_63", 6'd63, 6'd63, 6'd1,  6'd0,  1'b0, 1'b1);
    run_div("d20_0",  6'd20, 6'd0,  6'd63, 6'd20, 1'b1, 1'b1);
    run_div("d12_5",  6'd12, 6'd5,  6'd2,  6'd2,  1'b0, 1'b1);

    // Start held high; inputs change during RUN, second op accepted in DONE.
    @(negedge clk);
    a = 6'd10; b = 6'd3; start = 1'b1;
    @(posedge clk); #1;
    chk("held_busy", busy, 1);
    @(negedge clk);
    a = 6'd50; b = 6'd7;
    @(posedge clk); #1;
    wait_busy(n);
    chk("held_first_busy_cycles", n + 1, 6);
    chk("held_first_done", done, 1);
    chk("held_first_quotient", quotient, 3);
    chk("held_first_remainder", remainder, 1);
    @(posedge clk); #1;
    start = 1'b0;
    exp_dones = exp_dones + 2;
    chk("held_b2b_done_low", done, 0);
    chk("held_b2b_busy", busy, 1);
    wait_busy(n);
    chk("held_second_busy_cycles", n, 6);
    chk("held_second_done", done, 1);
    chk("held_second_quotient", quotient, 7);
    chk("held_second_remainder", remainder, 1);
    @(posedge clk); #1;

    // Reset on the third RUN cycle aborts the operation.
    @(negedge clk);
    a = 6'd40; b = 6'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    run_div("d40_6", 6'd40, 6'd6, 6'd6, 6'd4, 1'b0, 1'b1);

    // Exhaustive sweep against integer division.
    for (int ia = 0; ia < 64; ia++) begin
      for (int ib = 1; ib < 64; ib++) begin
        run_div("sweep", 6'(ia), 6'(ib), 6'(ia / ib), 6'(ia % ib), 1'b0, 1'b0);
      end
    end

    @(posedge clk); #1;
    chk("done_pulse_count", seen_dones, exp_dones);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
